lcd_driver: RTL



---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_timer.sv | 23 ++
 rtl/lcd_driver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and command constants for the HD44780 character LCD driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWER_WAIT,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    IDLE
  } lcd_state_t;

  // Where the write engine returns once EXEC completes.
  typedef enum logic [1:0] {
    PH_INIT,
    PH_CHAR,
    PH_WRAP
  } lcd_phase_t;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_LINE1        = 8'h80;
  localparam logic [7:0] CMD_LINE2        = 8'hC0;
  localparam int         INIT_LEN         = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = CMD_FUNCTION_SET;
      2'd1:    init_cmd = CMD_DISPLAY_ON;
      2'd2:    init_cmd = CMD_CLEAR;
      default: init_cmd = CMD_ENTRY_MODE;
    endcase
  endfunction

  function automatic int max2(input int a, input int b);
    max2 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_timer #(
  parameter int           W         = 21,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                cnt_q <= RESET_VAL;
    else if (load_i)          cnt_q <= load_val_i;
    else if (cnt_q != '0)     cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_driver.sv
// HD44780 8-bit write-only driver with built-in power-on init sequence.
// Optional macro LCD_LINE_WRAP_EN: cursor moves to line 2 / line 1 before characters 16 / 32.
//
// state      | meaning
// POWER_WAIT | waiting for panel power-up after reset
// SETUP      | RS/data settling before E rises
// PULSE      | E high
// HOLD       | RS/data held after E falls
// EXEC       | waiting for the panel to execute the write
// IDLE       | ready, lcd_busy low
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 750000,
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 25,
  parameter int HOLD_CYCLES    = 2,
  parameter int EXEC_CYCLES    = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_ready,
  input  logic [7:0] data_in,
  output logic       lcd_busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int MAXC = max2(max2(max2(POWERUP_CYCLES, SETUP_CYCLES), max2(PULSE_CYCLES, HOLD_CYCLES)),
                             max2(EXEC_CYCLES, CLEAR_CYCLES));
  localparam int CW   = $clog2(MAXC) + 1;

  lcd_state_t  state_q, state_d;
  lcd_phase_t  phase_q, phase_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d, e_q, e_d, rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;
`ifdef LCD_LINE_WRAP_EN
  logic [5:0]  col_q, col_d;
  logic [7:0]  char_q, char_d;
`endif

  lcd_timer #(.W(CW), .RESET_VAL(CW'(POWERUP_CYCLES - 1))) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= POWER_WAIT;
      phase_q <= PH_INIT;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
`ifdef LCD_LINE_WRAP_EN
      col_q   <= '0;
      char_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
`ifdef LCD_LINE_WRAP_EN
      col_q   <= col_d;
      char_q  <= char_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    e_d      = 1'b0;
    rs_d     = rs_q;
    data_d   = data_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef LCD_LINE_WRAP_EN
    col_d    = col_q;
    char_d   = char_q;
`endif
    case (state_q)
      POWER_WAIT: if (tmr_done) begin
        state_d  = SETUP;
        phase_d  = PH_INIT;
        idx_d    = '0;
        rs_d     = 1'b0;
        data_d   = init_cmd(2'd0);
        tmr_load = 1'b1;
        tmr_val  = CW'(SETUP_CYCLES - 1);
      end
      SETUP: if (tmr_done) begin
        state_d  = PULSE;
        e_d      = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = CW'(PULSE_CYCLES - 1);
      end
      PULSE: begin
        e_d = !tmr_done;
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = CW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: if (tmr_done) begin
        state_d  = EXEC;
        tmr_load = 1'b1;
        if (phase_q == PH_INIT && data_q == CMD_CLEAR) begin
          tmr_val = CW'(CLEAR_CYCLES - 1);
`ifdef LCD_LINE_WRAP_EN
          col_d   = '0;
`endif
        end else begin
          tmr_val = CW'(EXEC_CYCLES - 1);
        end
      end
      EXEC: if (tmr_done) begin
        case (phase_q)
          PH_INIT: begin
            if (idx_q == 2'(INIT_LEN - 1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d  = SETUP;
              idx_d    = idx_q + 2'd1;
              data_d   = init_cmd(idx_q + 2'd1);
              tmr_load = 1'b1;
              tmr_val  = CW'(SETUP_CYCLES - 1);
            end
          end
`ifdef LCD_LINE_WRAP_EN
          PH_WRAP: begin
            // Cursor command done; character pass follows inside the same busy window.
            state_d  = SETUP;
            phase_d  = PH_CHAR;
            rs_d     = 1'b1;
            data_d   = char_q;
            tmr_load = 1'b1;
            tmr_val  = CW'(SETUP_CYCLES - 1);
          end
`endif
          default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        endcase
      end
      IDLE: if (data_ready) begin
        state_d  = SETUP;
        busy_d   = 1'b1;
        phase_d  = PH_CHAR;
        rs_d     = 1'b1;
        data_d   = data_in;
        tmr_load = 1'b1;
        tmr_val  = CW'(SETUP_CYCLES - 1);
`ifdef LCD_LINE_WRAP_EN
        col_d    = (col_q == 6'd32) ? 6'd1 : col_q + 6'd1;
        if (col_q == 6'd16 || col_q == 6'd32) begin
          phase_d = PH_WRAP;
          rs_d    = 1'b0;
          data_d  = (col_q == 6'd16) ? CMD_LINE2 : CMD_LINE1;
          char_d  = data_in;
        end
`endif
      end
      default: state_d = POWER_WAIT;
    endcase
  end

  assign lcd_busy = busy_q;
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;

endmodule
